// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART types and constants for the transmit stream and the
//           receive VIP.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_stream_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with first-word-fall-through read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_cnt;
  logic [c_aw:0]    r_rd_cnt;
  logic [c_aw:0]    w_level;
  logic             w_do_push;
  logic             w_do_pop;

  // Counters carry one extra bit so full and empty stay distinguishable.
  assign w_level   = r_wr_cnt - r_rd_cnt;
  assign o_level   = w_level;
  assign o_full    = (w_level == (c_aw+1)'(DEPTH));
  assign o_empty   = (w_level == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_cnt[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_do_push) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_do_pop)  r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_cnt[c_aw-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_stream.sv
// ============================================================================
// Module  : uart_tx_stream
// Purpose : FIFO-buffered 8N1 UART transmitter fed by a valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUDRATE = 25000000,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int              c_div       = uart_div(CLK_HZ, BAUDRATE);
  localparam int              c_cnt_w     = $clog2(c_div);
  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(c_div - 1);

  if (c_div < 2 || (CLK_HZ % BAUDRATE) != 0) begin : g_bad_div
    $error("uart_tx_stream: CLK_HZ/BAUDRATE must be an integer >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_stream: DEPTH must be a power of two >= 2");
  end
  if (UART_STOP_BITS != 1) begin : g_bad_stop
    $error("uart_tx_stream: only one stop bit is implemented");
  end

  uart_state_t        r_state;
  uart_state_t        w_state_nxt;
  logic [c_cnt_w-1:0] r_baud;
  logic [2:0]         r_bitcnt;
  logic [7:0]         r_shreg;
  logic               r_tx;
  logic               w_pop;
  logic               w_push;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [7:0]         w_fifo_rdata;
  logic               w_baud_last;
  logic               w_last_bit;
  logic               w_line;

  assign w_push   = in_valid && in_ready;
  assign in_ready = !w_fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (level)
  );

  assign w_baud_last = (r_baud == c_baud_last);
  assign w_last_bit  = (r_bitcnt == 3'(UART_DATA_BITS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_last) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_baud_last && w_last_bit) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_baud_last) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_line = (r_state == START) ? 1'b0 :
                  (r_state == DATA)  ? r_shreg[0] : 1'b1;

  // Every state exit coincides with a bit end, so clearing on bit end
  // also clears the counter on each state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_tx     <= 1'b1;
    end else begin
      if (r_state == IDLE || w_baud_last) r_baud <= '0;
      else                                r_baud <= r_baud + 1'b1;

      if (w_pop)                             r_shreg <= w_fifo_rdata;
      else if (r_state == DATA && w_baud_last) r_shreg <= r_shreg >> 1;

      if (r_state != DATA)  r_bitcnt <= '0;
      else if (w_baud_last) r_bitcnt <= r_bitcnt + 1'b1;

      r_tx <= w_line;
    end
  end

  assign uart_tx = r_tx;
  assign busy    = (r_state != IDLE) || !w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
// ============================================================================
// Module  : tb_uart_tx_stream
// Purpose : Directed and randomized checks of uart_tx_stream at DIV 2, 4, 5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_stream;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] tx;
  logic [2:0] bsy;
  logic [7:0] din [3];
  logic [3:0] lvl [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int divof(input int g);
    return (g == 0) ? 2 : (g == 1) ? 4 : 5;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int D = divof(g);

    uart_tx_stream #(
      .CLK_HZ   (50000000),
      .BAUDRATE (50000000 / D),
      .DEPTH    (8)
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .in_valid (vld[g]),
      .in_data  (din[g]),
      .in_ready (rdy[g]),
      .uart_tx  (tx[g]),
      .busy     (bsy[g]),
      .level    (lvl[g])
    );

    // Line receiver: finds the start bit, samples mid-bit, checks stop bit.
    logic [7:0] rxq [$];
    int         ferr = 0;
    bit         act  = 1'b0;
    int         cnt  = 0;
    logic [7:0] sh   = 8'h00;

    initial begin
      forever begin
        @(negedge clk);
        if (rst[g] !== 1'b0) begin
          act = 1'b0;
        end else if (!act) begin
          if (tx[g] === 1'b0) begin
            act = 1'b1;
            cnt = 0;
          end
        end else begin
          cnt++;
          if (cnt % D == D / 2) begin
            if (cnt / D >= 1 && cnt / D <= 8) begin
              sh[3'(cnt / D - 1)] = tx[g];
            end else if (cnt / D == 9) begin
              if (tx[g] !== 1'b1) ferr++;
              rxq.push_back(sh);
              act = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pushes n (1 or 2) bytes on consecutive edges into an idle DUT and checks
  // the line and busy cycle by cycle against the ideal 8N1 waveform.
  task automatic send_frames(input int g, input logic [7:0] b0, input logic [7:0] b1, input int n);
    int         d;
    int         flen;
    int         bi;
    logic       exp_tx;
    logic [7:0] cur;
    d    = divof(g);
    flen = 10 * d;
    @(negedge clk);
    vld[g] = 1'b1;
    din[g] = b0;
    for (int t = 0; t <= n * flen + 2; t++) begin
      @(negedge clk);
      if (t + 1 < n) din[g] = b1;
      else           vld[g] = 1'b0;
      exp_tx = 1'b1;
      if (t >= 2 && t < 2 + n * flen) begin
        cur = ((t - 2) / flen == 0) ? b0 : b1;
        bi  = ((t - 2) % flen) / d;
        if (bi == 0)      exp_tx = 1'b0;
        else if (bi <= 8) exp_tx = cur[3'(bi - 1)];
      end
      chk("line", tx[g], exp_tx);
      chk("busy", bsy[g], (t <= n * flen) ? 1 : 0);
    end
  endtask

  logic [7:0] got;
  logic [7:0] expq [$];
  int         acc_t [10];
  int         idx;
  int         mism;
  int         zeros;
  int         maxl;
  int         cyc;
  bit         will;

  initial begin
    rst = 3'b111;
    vld = 3'b000;
    for (int g = 0; g < 3; g++) din[g] = 8'h00;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_tx",    tx[g],  1);
      chk("reset_ready", rdy[g], 1);
      chk("reset_busy",  bsy[g], 0);
      chk("reset_level", lvl[g], 0);
    end
    rst = 3'b000;
    repeat (2) @(negedge clk);

    // Single 0x55 frame at DIV=2
    send_frames(0, 8'h55, 8'h00, 1);
    repeat (2) @(negedge clk);
    chk("rx55_count", g_inst[0].rxq.size(), 1);
    got = (g_inst[0].rxq.size() != 0) ? g_inst[0].rxq.pop_front() : 8'hxx;
    chk("rx55_data", got, 8'h55);
    g_inst[0].rxq.delete();

    // Back-to-back 0xA3, 0x0F with no idle gap
    send_frames(0, 8'hA3, 8'h0F, 2);
    repeat (2) @(negedge clk);
    chk("b2b_count", g_inst[0].rxq.size(), 2);
    got = (g_inst[0].rxq.size() != 0) ? g_inst[0].rxq.pop_front() : 8'hxx;
    chk("b2b_first", got, 8'hA3);
    got = (g_inst[0].rxq.size() != 0) ? g_inst[0].rxq.pop_front() : 8'hxx;
    chk("b2b_second", got, 8'h0F);
    g_inst[0].rxq.delete();

    // Burst of 10 with in_valid held: 9 at once, the 10th after the first pop
    idx  = 0;
    will = 1'b0;
    cyc  = 0;
    maxl = 0;
    for (int i = 0; i < 10; i++) acc_t[i] = -1;
    while (idx < 10 && cyc < 500) begin
      @(negedge clk);
      if (will) idx++;
      if (int'(lvl[0]) > maxl) maxl = int'(lvl[0]);
      if (idx < 10) begin
        vld[0] = 1'b1;
        din[0] = 8'(idx);
        will   = rdy[0];
        if (will) acc_t[idx] = cyc;
      end else begin
        vld[0] = 1'b0;
        will   = 1'b0;
      end
      cyc++;
    end
    vld[0] = 1'b0;
    for (int i = 0; i < 10; i++) chk("burst_accept_cycle", acc_t[i], (i < 9) ? i : 10 * 2 + 2);
    chk("burst_level_max", maxl, 8);
    for (int i = 0; i < 400 && (g_inst[0].rxq.size() < 10 || bsy[0]); i++) @(negedge clk);
    chk("burst_rx_count", g_inst[0].rxq.size(), 10);
    mism = 0;
    for (int i = 0; i < 10; i++) begin
      got = (g_inst[0].rxq.size() != 0) ? g_inst[0].rxq.pop_front() : 8'hxx;
      if (got !== 8'(i)) mism++;
    end
    chk("burst_rx_order", mism, 0);
    repeat (4) @(negedge clk);

    // Reset during the DATA state of 0xFF with three bytes queued
    vld[0] = 1'b1;
    din[0] = 8'hFF;
    @(negedge clk); din[0] = 8'h01;
    @(negedge clk); din[0] = 8'h02;
    @(negedge clk); din[0] = 8'h03;
    @(negedge clk); vld[0] = 1'b0;
    @(negedge clk);
    chk("abort_level_before", lvl[0], 3);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_tx",    tx[0],  1);
    chk("abort_level", lvl[0], 0);
    chk("abort_busy",  bsy[0], 0);
    chk("abort_ready", rdy[0], 1);
    rst[0] = 1'b0;
    zeros = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || bsy[0] !== 1'b0) zeros++;
    end
    chk("abort_quiet", zeros, 0);
    chk("abort_rx_count", g_inst[0].rxq.size(), 0);

    // 0x80 at DIV=5: 50-cycle frame, last data bit high
    send_frames(2, 8'h80, 8'h00, 1);
    repeat (2) @(negedge clk);
    chk("div5_count", g_inst[2].rxq.size(), 1);
    got = (g_inst[2].rxq.size() != 0) ? g_inst[2].rxq.pop_front() : 8'hxx;
    chk("div5_data", got, 8'h80);

    // 200 random bytes with random valid gaps at DIV=4
    will = 1'b0;
    cyc  = 0;
    maxl = 0;
    while (expq.size() < 200 && cyc < 20000) begin
      @(negedge clk);
      if (will) expq.push_back(din[1]);
      if (int'(lvl[1]) > maxl) maxl = int'(lvl[1]);
      if (expq.size() < 200) begin
        vld[1] = ($urandom_range(0, 3) != 0);
        din[1] = 8'($urandom);
      end else begin
        vld[1] = 1'b0;
      end
      will = vld[1] && rdy[1];
      cyc++;
    end
    vld[1] = 1'b0;
    chk("rand_accepted", expq.size(), 200);
    for (int i = 0; i < 10000 && (g_inst[1].rxq.size() < 200 || bsy[1]); i++) @(negedge clk);
    chk("rand_rx_count", g_inst[1].rxq.size(), 200);
    mism = 0;
    while (expq.size() != 0) begin
      got = (g_inst[1].rxq.size() != 0) ? g_inst[1].rxq.pop_front() : 8'hxx;
      if (got !== expq.pop_front()) mism++;
    end
    chk("rand_rx_order", mism, 0);
    chk("rand_level_bound", (maxl <= 8) ? 1 : 0, 1);

    chk("framing_div2", g_inst[0].ferr, 0);
    chk("framing_div4", g_inst[1].ferr, 0);
    chk("framing_div5", g_inst[2].ferr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_stream.md
# uart_tx_stream

Synthesizable UART transmitter with an input FIFO. It drives the chip-side `uart_rx` line, which is the opposite direction from the existing UART receive VIP path. Bytes are accepted through a valid/ready stream, buffered, and serialized as 8N1 frames, LSB first, at `CLK_HZ/BAUDRATE` clocks per bit. It is used in the chip as the console transmit path and in benches as a stimulus source for `uart_rx`.

## Interface
- `CLK_HZ`, 50000000: system clock frequency.
- `BAUDRATE`, 25000000: line rate. `DIV = CLK_HZ/BAUDRATE` is an integer and must be ≥ 2; elaboration fails otherwise.
- `DEPTH`, 8: FIFO depth in bytes. Must be a power of two and ≥ 2.

Ports:
- `clk` in 1: the single clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: a byte is offered.
- `in_data` in 8: the offered byte.
- `in_ready` out 1: the FIFO can accept a byte. Reset value 1.
- `uart_tx` out 1: serial line, registered, idles high. Reset value 1.
- `busy` out 1: a frame is in progress or the FIFO is non-empty. Reset value 0.
- `level` out `$clog2(DEPTH)+1`: current FIFO occupancy. Reset value 0.

## Operation
- Push occurs on `in_valid && in_ready` at a rising edge.
- `in_ready = (level != DEPTH)`. It is registered or derived only from state and never depends on `in_valid`.
- FSM states:
  - IDLE → START when the FIFO is non-empty. The byte is popped into `shreg` on the same edge.
  - START: line is 0 for `DIV` cycles, then → DATA with `bitcnt=0`.
  - DATA: line is `shreg[0]` for `DIV` cycles, then shift right and increment `bitcnt`. After bit 7 → STOP.
  - STOP: line is 1 for `DIV` cycles. At the end, if the FIFO is non-empty, pop and go → START. There is no idle gap between frames. Otherwise → IDLE.
- Baud counter:
  - Width is `$clog2(DIV)`.
  - It counts 0..DIV-1 and is cleared on every state entry.
  - A bit ends when the count reaches DIV-1.
- FIFO full and the FSM pops in the same cycle: no push that cycle, because `in_ready` was 0. `in_ready` becomes 1 the following cycle.
- FIFO empty and a push in the same cycle as the FSM checks for non-empty: the FSM sees the byte on the next cycle. There is no bypass path.
- Pointers wrap modulo `DEPTH`. `level` is maintained as `wr_cnt - rd_cnt` using `$clog2(DEPTH)+1`-bit counters.
- Reset during a frame:
  - The frame is aborted and the FIFO flushed.
  - `uart_tx` is 1 from the cycle after the reset edge.
  - A truncated frame on the line is acceptable.

## Timing
- Latency:
  - Byte accepted at edge N into an empty FIFO with the FSM in IDLE.
  - Pop at edge N+1.
  - Start bit visible on `uart_tx` after edge N+2.
- Frame length is exactly `10*DIV` cycles. Back-to-back frames repeat every `10*DIV` cycles.
- `busy` rises the cycle after the first push. It falls the cycle after STOP completes with an empty FIFO.
- Throughput: one byte per `10*DIV` cycles sustained. Input bursts of up to `DEPTH` bytes are accepted at one byte per cycle.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum: IDLE, START, DATA, STOP.
  - Constants `UART_DATA_BITS=8` and `UART_STOP_BITS=1`.
  - Function `uart_div(clk_hz, baud)`.
  - The existing receive VIP shares this package.
- One sub-module, `sync_fifo`:
  - Parameterized width and depth.
  - Ports: push/pop, full/empty, level.
  - First-word data available combinationally at the read port.
- Top level contains the FSM, the baud counter, and the shift register.

## Test plan
- DIV=2, push 0x55 once → `uart_tx` = 0,1,0,1,0,1,0,1,0,1, each level held 2 cycles. Start bit begins 2 cycles after acceptance. `busy` is low 21 cycles after acceptance.
- DIV=2, push 0xA3 and 0x0F back-to-back → two frames of 20 cycles each. The second start bit immediately follows the first stop bit, with no idle cycle. The `uart_rx` loopback VIP decodes 0xA3, 0x0F.
- DEPTH=8, hold `in_valid` with 10 bytes, 0x00..0x09 → exactly 9 accepted at once (8 in the FIFO, 1 popped into the shifter). Then `in_ready` is 0 until the first frame's STOP completes and pops. All 10 bytes are received in order.
- `reset` asserted in the DATA state of the frame for 0xFF, with 3 bytes queued → `uart_tx`=1, `level`=0, `busy`=0, and `in_ready`=1 the cycle after the reset edge. No further frames.
- DIV=5 (CLK_HZ=50000000, BAUDRATE=10000000), push 0x80 → each bit lasts 5 cycles. Bit 7 is the last data bit and is high. Frame is 50 cycles.
- Random `in_valid` gaps, 200 bytes, DIV=4 → the VIP-decoded sequence equals the pushed sequence. `level` never exceeds 8.
